// File: rtl/lsu_align_seq_pkg.sv
// Shared types, funct3 encodings and size helpers for the load/store alignment sequencer.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_seq_if.sv
// Pipeline request/response and data-memory port bundle of the load/store sequencer.
interface lsu_align_seq_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              stall;
  logic              resp_valid;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;

  // master is the sequencer itself; slave is the pipeline plus memory around it
  modport master (
    input  req_valid, mem_read, mem_write, funct3, addr, wdata, mem_rdata,
    output stall, resp_valid, rdata, mem_addr, mem_be, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output req_valid, mem_read, mem_write, funct3, addr, wdata, mem_rdata,
    input  stall, resp_valid, rdata, mem_addr, mem_be, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/lsu_align_seq_load_extract.sv
// Realigns a two-word load window by the byte offset and applies sign/zero extension.
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] win;

  always_comb begin
    win = 32'({hi, lo} >> {off, 3'b000});
    case (funct3)
      F3_LB:   rdata = {{24{win[7]}}, win[7:0]};
      F3_LH:   rdata = {{16{win[15]}}, win[15:0]};
      F3_LBU:  rdata = {24'd0, win[7:0]};
      F3_LHU:  rdata = {16'd0, win[15:0]};
      default: rdata = win;
    endcase
  end

endmodule

// File: rtl/lsu_align_seq.sv
// Load/store sequencer: byte-addressed accesses to word cycles with byte enables,
// splitting word-crossing accesses in two and stalling the pipeline until done.
//
//   state | meaning
//   IDLE  | waiting for a memory instruction
//   ACC0  | first (or only) word cycle on the memory port
//   ACC1  | second word cycle of a word-crossing access
//   WAIT  | load: last read word arrives on mem_rdata
//   RESP  | access complete, pipeline released
module lsu_align_seq
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic           clk,
  input  logic           reset,
  lsu_align_seq_if.master bus
);

  state_t            state_q, state_d;
  logic              op_rd_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] widx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              sel_rd;
  logic [2:0]        sel_f3;
  logic [1:0]        sel_off;
  logic [ADDR_W-1:0] sel_widx;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_mask;
  logic              sel_cross;

  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [3:0]        mem_be_d, mem_be_q;
  logic [31:0]       mem_wdata_d, mem_wdata_q;
  logic              mem_we_d, mem_we_q;
  logic              mem_re_d, mem_re_q;

  logic [31:0]       ext_lo;
  logic [31:0]       ext_data;

  // In IDLE the incoming request drives the first memory cycle directly so the
  // registered port shows it in ACC0; afterwards the latched copy is used.
  always_comb begin
    accept    = (state_q == IDLE) && bus.req_valid && (bus.mem_read || bus.mem_write) && !reset;
    sel_rd    = (state_q == IDLE) ? bus.mem_read : op_rd_q;
    sel_f3    = (state_q == IDLE) ? bus.funct3 : f3_q;
    sel_off   = (state_q == IDLE) ? bus.addr[1:0] : off_q;
    sel_widx  = (state_q == IDLE) ? bus.addr[ADDR_W+1:2] : widx_q;
    sel_wdata = (state_q == IDLE) ? bus.wdata : wdata_q;
    sel_mask  = size_mask(sel_f3[1:0]);
    sel_cross = ({1'b0, sel_off} + size_bytes(sel_f3[1:0])) > 3'd4;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = ACC0;
      ACC0: begin
        if (sel_cross)   state_d = ACC1;
        else if (sel_rd) state_d = WAIT;
        else             state_d = RESP;
      end
      ACC1:    state_d = sel_rd ? WAIT : RESP;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d  = '0;
    mem_be_d    = 4'b0000;
    mem_wdata_d = 32'd0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    if (state_d == ACC0) begin
      mem_addr_d  = sel_widx;
      mem_be_d    = sel_mask << sel_off;
      mem_wdata_d = sel_wdata << {sel_off, 3'b000};
      mem_we_d    = !sel_rd;
      mem_re_d    = sel_rd;
    end else if (state_d == ACC1) begin
      mem_addr_d  = sel_widx + {{(ADDR_W-1){1'b0}}, 1'b1};
      mem_be_d    = sel_mask >> (3'd4 - {1'b0, sel_off});
      mem_wdata_d = sel_wdata >> {(3'd4 - {1'b0, sel_off}), 3'b000};
      mem_we_d    = !sel_rd;
      mem_re_d    = sel_rd;
    end
  end

  // Aligned loads use the single read word for both halves of the window.
  assign ext_lo = sel_cross ? lo_q : bus.mem_rdata;

  load_extract u_load_extract (
    .hi     (bus.mem_rdata),
    .lo     (ext_lo),
    .off    (off_q),
    .funct3 (f3_q),
    .rdata  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_rd_q     <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      widx_q      <= '0;
      wdata_q     <= 32'd0;
      lo_q        <= 32'd0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      if (accept) begin
        op_rd_q <= bus.mem_read;
        f3_q    <= bus.funct3;
        off_q   <= bus.addr[1:0];
        widx_q  <= bus.addr[ADDR_W+1:2];
        wdata_q <= bus.wdata;
      end
      if (state_q == ACC1 && op_rd_q) lo_q <= bus.mem_rdata;
      if (state_q == WAIT) rdata_q <= ext_data;
    end
  end

  assign bus.stall      = !reset && (accept || state_q == ACC0 || state_q == ACC1 || state_q == WAIT);
  assign bus.resp_valid = !reset && (state_q == RESP);
  assign bus.rdata      = rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_re     = mem_re_q;

endmodule

// File: tb/tb_lsu_align_seq.sv
// Directed bench for lsu_align_seq with a behavioural word memory on the port.
module tb_lsu_align_seq;
  import lsu_pkg::*;

  localparam int ADDR_W = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_align_seq_if #(.ADDR_W(ADDR_W)) bus();

  lsu_align_seq #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in cycle T, checks stall there, returns 1 time unit into T+1.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    #1;
    chk({tag, "_stall_T"}, bus.stall, 1);
    step();
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic chk_idle_port(input string tag);
    chk({tag, "_we"}, bus.mem_we, 0);
    chk({tag, "_re"}, bus.mem_re, 0);
    chk({tag, "_be"}, bus.mem_be, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.funct3    = 3'd0;
    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_resp", bus.resp_valid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk_idle_port("rst");
    chk("rst_state", dut.state_q, IDLE);
    @(negedge clk);
    reset = 1'b0;
    step();

    // aligned SW 0x10
    issue(1'b0, 1'b1, F3_LW, 32'h10, 32'hDEADBEEF, "sw");
    chk("sw_addr", bus.mem_addr, 4);
    chk("sw_be", bus.mem_be, 4'b1111);
    chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("sw_we", bus.mem_we, 1);
    chk("sw_re", bus.mem_re, 0);
    chk("sw_stall_T1", bus.stall, 1);
    chk("sw_resp_T1", bus.resp_valid, 0);
    step();
    chk("sw_resp_T2", bus.resp_valid, 1);
    chk("sw_stall_T2", bus.stall, 0);
    chk_idle_port("sw_T2");
    step();

    // SB at byte offset 3
    issue(1'b0, 1'b1, F3_LB, 32'h13, 32'h000000A5, "sb");
    chk("sb_be", bus.mem_be, 4'b1000);
    chk("sb_wdata", bus.mem_wdata, 32'hA5000000);
    chk("sb_we", bus.mem_we, 1);
    step();
    chk("sb_resp_T2", bus.resp_valid, 1);
    chk("sb_we_T2", bus.mem_we, 0);
    step();

    // LB 0x13 (word 4 now A5ADBEEF)
    issue(1'b1, 1'b0, F3_LB, 32'h13, 32'd0, "lb");
    chk("lb_re", bus.mem_re, 1);
    chk("lb_we", bus.mem_we, 0);
    chk("lb_addr", bus.mem_addr, 4);
    step();
    chk("lb_re_T2", bus.mem_re, 0);
    chk("lb_stall_T2", bus.stall, 1);
    chk("lb_resp_T2", bus.resp_valid, 0);
    step();
    chk("lb_resp_T3", bus.resp_valid, 1);
    chk("lb_rdata", bus.rdata, 32'hFFFFFFA5);
    step();

    // LBU 0x13
    issue(1'b1, 1'b0, F3_LBU, 32'h13, 32'd0, "lbu");
    step();
    chk("lbu_resp_T2", bus.resp_valid, 0);
    step();
    chk("lbu_resp_T3", bus.resp_valid, 1);
    chk("lbu_rdata", bus.rdata, 32'h000000A5);
    step();

    // fill words 4 and 5; rdata must hold across stores
    issue(1'b0, 1'b1, F3_LW, 32'h10, 32'h44332211, "fill4");
    step();
    chk("fill4_resp", bus.resp_valid, 1);
    chk("fill4_rdata_hold", bus.rdata, 32'h000000A5);
    step();
    issue(1'b0, 1'b1, F3_LW, 32'h14, 32'h88776655, "fill5");
    step();
    chk("fill5_resp", bus.resp_valid, 1);
    step();

    // misaligned LW 0x12
    issue(1'b1, 1'b0, F3_LW, 32'h12, 32'd0, "mlw");
    chk("mlw_re0", bus.mem_re, 1);
    chk("mlw_addr0", bus.mem_addr, 4);
    chk("mlw_be0", bus.mem_be, 4'b1100);
    step();
    chk("mlw_re1", bus.mem_re, 1);
    chk("mlw_addr1", bus.mem_addr, 5);
    chk("mlw_be1", bus.mem_be, 4'b0011);
    chk("mlw_stall_T2", bus.stall, 1);
    step();
    chk("mlw_re_T3", bus.mem_re, 0);
    chk("mlw_resp_T3", bus.resp_valid, 0);
    step();
    chk("mlw_resp_T4", bus.resp_valid, 1);
    chk("mlw_rdata", bus.rdata, 32'h66554433);
    step();

    // misaligned SH wrapping past the top word
    issue(1'b0, 1'b1, F3_LH, 32'h7FF, 32'h0000BBAA, "msh");
    chk("msh_addr0", bus.mem_addr, 9'h1FF);
    chk("msh_be0", bus.mem_be, 4'b1000);
    chk("msh_wdata0", bus.mem_wdata, 32'hAA000000);
    chk("msh_we0", bus.mem_we, 1);
    step();
    chk("msh_addr1", bus.mem_addr, 0);
    chk("msh_be1", bus.mem_be, 4'b0001);
    chk("msh_wdata1", bus.mem_wdata, 32'h000000BB);
    chk("msh_we1", bus.mem_we, 1);
    step();
    chk("msh_resp_T3", bus.resp_valid, 1);
    chk("msh_rdata_hold", bus.rdata, 32'h66554433);
    step();

    // read the wrapped halfword back, unsigned and signed
    issue(1'b1, 1'b0, F3_LHU, 32'h7FF, 32'd0, "lhu");
    step();
    step();
    step();
    chk("lhu_resp_T4", bus.resp_valid, 1);
    chk("lhu_rdata", bus.rdata, 32'h0000BBAA);
    step();
    issue(1'b1, 1'b0, F3_LH, 32'h7FF, 32'd0, "lh");
    step();
    step();
    step();
    chk("lh_rdata", bus.rdata, 32'hFFFFBBAA);
    step();

    // read and write both high: treated as a read
    issue(1'b1, 1'b1, F3_LW, 32'h14, 32'h12345678, "rw");
    chk("rw_re", bus.mem_re, 1);
    chk("rw_we", bus.mem_we, 0);
    step();
    chk("rw_we_T2", bus.mem_we, 0);
    step();
    chk("rw_resp_T3", bus.resp_valid, 1);
    chk("rw_rdata", bus.rdata, 32'h88776655);
    step();

    // reset during ACC1 of a misaligned LW
    issue(1'b1, 1'b0, F3_LW, 32'h12, 32'd0, "rst_mid");
    step();
    chk("rst_mid_acc1_re", bus.mem_re, 1);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rst_mid_state", dut.state_q, IDLE);
    chk("rst_mid_stall", bus.stall, 0);
    chk("rst_mid_resp", bus.resp_valid, 0);
    chk("rst_mid_rdata", bus.rdata, 0);
    chk_idle_port("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rst_mid_after_re", bus.mem_re, 0);
    chk("rst_mid_after_resp", bus.resp_valid, 0);

    // fresh aligned LW after reset
    issue(1'b1, 1'b0, F3_LW, 32'h10, 32'd0, "post_lw");
    chk("post_lw_re", bus.mem_re, 1);
    step();
    chk("post_lw_resp_T2", bus.resp_valid, 0);
    step();
    chk("post_lw_resp_T3", bus.resp_valid, 1);
    chk("post_lw_rdata", bus.rdata, 32'h44332211);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_align_seq.md
Name: lsu_align_seq

Overview:
- Load/store sequencer between the EX/MEM pipeline register and the data-memory port.
- Converts a byte-addressed access (`addr`, `funct3`, `mem_read`/`mem_write`) into word-addressed memory cycles with byte enables.
- Splits misaligned halfword/word accesses into two word cycles and realigns plus sign/zero-extends load data.
- Stalls the pipeline until the access completes.

Parameters:
- `ADDR_W`, 9, word-index width of the memory port; the word index is `addr[ADDR_W+1:2]`.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: EX/MEM holds a memory instruction.
- `mem_read` in 1: load request from the control unit.
- `mem_write` in 1: store request from the control unit.
- `funct3` in 3: instruction bits 14:12.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `stall` out 1: freeze the pipeline front-end.
- `resp_valid` out 1: access complete this cycle.
- `rdata` out 32: aligned, extended load result.
- `mem_addr` out ADDR_W: word index to memory.
- `mem_be` out 4: byte write enables.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_we` out 1: memory write strobe.
- `mem_re` out 1: memory read strobe.
- `mem_rdata` in 32: memory read data, valid one cycle after `mem_re`.

Behaviour:
- Reset: synchronous, active-high. All outputs are 0 and the state is `IDLE`. Reset asserted mid-operation aborts the access with no further `mem_we`/`mem_re`. A partial misaligned store may leave only its first word written.
- Size decode from `funct3[1:0]`: 0 → 1 byte, 1 → 2 bytes, 2 → 4 bytes, 3 → 4 bytes (word, same as funct3 default).
- Extension:
  - Sign-extend when `funct3` = 000 or 001.
  - Zero-extend when `funct3` = 100 or 101.
  - Other `funct3` values return the full word.
- Priority: if `mem_read` and `mem_write` are both high, the access is a read.
- Acceptance: in `IDLE`, `req_valid & (mem_read|mem_write)` latches `addr`, `wdata`, `funct3` and the operation, and moves to `ACC0`. `stall` is asserted combinationally in the acceptance cycle.
- Offset and crossing: `off = addr[1:0]`. The access is cross-word when `off + size > 4`.
- `ACC0`:
  - Drive `mem_addr = widx`.
  - `mem_be = (size mask << off)[3:0]`.
  - `mem_wdata = wdata << 8*off`.
  - Pulse `mem_we` for a store or `mem_re` for a load.
  - Next state: `ACC1` if cross-word, else `WAIT` for a load or `RESP` for a store.
- `ACC1`:
  - Drive `mem_addr = widx+1`, wrapping modulo 2^ADDR_W.
  - `mem_be = size mask >> (4-off)`.
  - `mem_wdata = wdata >> 8*(4-off)`.
  - For a load, capture `mem_rdata` as the low word.
  - Next state: `WAIT` for a load, `RESP` for a store.
- `WAIT` (loads only): capture `mem_rdata` as the last word, then go to `RESP`.
- `RESP`:
  - `resp_valid=1` and `stall=0`.
  - For a load, `rdata = extend(({hi,lo} >> 8*off)[size])`.
  - Next state is `IDLE`.
  - `req_valid` is ignored in this cycle, since it is still the old instruction.
- `stall`: high from the acceptance cycle through the cycle before `RESP`.
- Latency, counted from acceptance cycle T to `resp_valid`:
  - Aligned store: T+2.
  - Misaligned store: T+3.
  - Aligned load: T+3.
  - Misaligned load: T+4.
- Output registers: `mem_*` outputs are registered and are 0 outside `ACC0`/`ACC1`. `rdata` holds its value until the next `RESP`.
- Address bits above `ADDR_W+1` are ignored, with no fault.

Decomposition:
- Shared package `lsu_pkg`:
  - `state_t` enum: `IDLE`, `ACC0`, `ACC1`, `WAIT`, `RESP`.
  - `funct3` constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - A `size_mask` function returning 4'b0001, 4'b0011 or 4'b1111.
- One sub-module, `load_extract`: combinational realign and extension from `{hi,lo}`, `off` and `funct3` to `rdata`.

Test Plan:
- Aligned SW: `addr`=0x10, `wdata`=0xDEADBEEF → T+1 shows `mem_addr`=4, `be`=1111, `wdata`=0xDEADBEEF, `we`=1. `resp_valid` at T+2. `stall` is high at T and T+1.
- SB at byte offset: `addr`=0x13, `wdata`=0x000000A5 → `be`=1000, `mem_wdata`=0xA5000000, a single write. Then LB at 0x13 returns 0xFFFFFFA5 and LBU returns 0x000000A5, each at T+3.
- Misaligned LW: word 4 = 0x44332211 and word 5 = 0x88776655; `addr`=0x12 → `re` at `mem_addr`=4 then 5. `rdata`=0x66554433 at T+4.
- Misaligned SH with wrap: `addr` = (2^ADDR_W-1)*4+3 = 0x7FF, `wdata`=0xBBAA → first write `be`=1000 with lane 3 = 0xAA. Second write `mem_addr`=0, `be`=0001, lane 0 = 0xBB.
- Read/write both high: `mem_read`=`mem_write`=1 → only `mem_re` is pulsed and `mem_we` stays 0 throughout.
- Reset mid-access: assert `reset` during `ACC1` of a misaligned LW → next cycle all outputs are 0 and the state is `IDLE`. A new aligned LW then completes at T+3.
